// File: rtl/frame_data_writer_pkg.sv
// Shared definitions for the frame data writer: header magic, FSM state
// encoding and default parameter values.
// Optional feature macro: FRAME_DATA_WRITER_CHECK_EN (adds the CHECK state).
package frame_cfg_pkg;

    // Upper 16 bits of a header word.
    localparam logic [15:0] FRAME_MAGIC = 16'hFAB0;

    localparam int DEF_FRAME_BITS_PER_ROW = 32;
    localparam int DEF_ROW_SELECT_WIDTH   = 5;
    localparam int DEF_NUMBER_OF_ROWS     = 12;
    localparam int DEF_FRAME_ADDR_WIDTH   = 5;

`ifdef FRAME_DATA_WRITER_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_STROBE = 2'd3
    } frame_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_STROBE = 2'd3
    } frame_state_e;
`endif

    // True when the upper half of a word carries the header magic.
    function automatic logic is_header(input logic [15:0] magic);
        return magic == FRAME_MAGIC;
    endfunction

endpackage

// File: rtl/frame_data_writer_if.sv
// Valid/ready stream carrying header, row data and check words into the
// frame data writer.
interface frame_data_writer_if #(
    parameter int Width = 32
) ();
    logic [Width-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_data_writer_row_counter.sv
// Row counter running 1..NumberOfRows: load restarts at row 1, increment
// advances, last flags the final row of the frame.
module frame_row_counter
    import frame_cfg_pkg::*;
#(
    parameter int NumberOfRows   = DEF_NUMBER_OF_ROWS,
    parameter int RowSelectWidth = DEF_ROW_SELECT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic                      inc_i,
    output logic [RowSelectWidth-1:0] count_o,
    output logic                      last_o
);

    localparam logic [RowSelectWidth-1:0] FirstRow = RowSelectWidth'(1);
    localparam logic [RowSelectWidth-1:0] LastRow  = RowSelectWidth'(NumberOfRows);

    logic [RowSelectWidth-1:0] count_q;
    logic [RowSelectWidth-1:0] count_d;

    // Next count: load wins, increment wraps back to the first row.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = FirstRow;
        end else if (inc_i) begin
            count_d = (count_q == LastRow) ? FirstRow : count_q + 1'b1;
        end
    end

    // Count register, reset to the first row.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            count_q <= FirstRow;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == LastRow);

endmodule

// File: rtl/frame_data_writer.sv
// Frame data writer: accepts a header word (magic 16'hFAB0 + frame index),
// then NumberOfRows data words, broadcasting each on FrameData with a
// 1-based RowSelect pulse, and finishes with a one-cycle FrameStrobe.
// Optional feature macro: FRAME_DATA_WRITER_CHECK_EN -- a trailing check
// word must equal the XOR of the frame's data words before the strobe.
module frame_data_writer
    import frame_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = DEF_FRAME_BITS_PER_ROW,
    parameter int RowSelectWidth  = DEF_ROW_SELECT_WIDTH,
    parameter int NumberOfRows    = DEF_NUMBER_OF_ROWS,
    parameter int FrameAddrWidth  = DEF_FRAME_ADDR_WIDTH
) (
    input  logic                       CLK,
    input  logic                       resetn,
    frame_data_writer_if.slave         s_if,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [RowSelectWidth-1:0]  RowSelect,
    output logic [FrameAddrWidth-1:0]  FrameAddr,
    output logic                       FrameStrobe,
    output logic                       err
);

    frame_state_e               state_q;
    logic                       s_ready_q;
    logic [FrameBitsPerRow-1:0] frame_data_q;
    logic [RowSelectWidth-1:0]  row_sel_q;
    logic [FrameAddrWidth-1:0]  frame_addr_q;
    logic                       strobe_q;
    logic                       err_q;
`ifdef FRAME_DATA_WRITER_CHECK_EN
    logic [FrameBitsPerRow-1:0] xor_q;
`endif

    logic                       fire;
    logic                       hdr_ok;
    logic                       cnt_load;
    logic                       cnt_inc;
    logic [RowSelectWidth-1:0]  row_cnt;
    logic                       row_last;

    assign fire   = s_if.s_valid && s_ready_q;
    assign hdr_ok = is_header(s_if.s_data[FrameBitsPerRow-1 -: 16]);

    // Counter control: restart on a good header, advance on each non-final row.
    assign cnt_load = fire && (state_q == ST_IDLE) && hdr_ok;
    assign cnt_inc  = fire && (state_q == ST_DATA) && !row_last;

    frame_row_counter #(
        .NumberOfRows   (NumberOfRows),
        .RowSelectWidth (RowSelectWidth)
    ) u_row_counter (
        .clk     (CLK),
        .rst_n   (resetn),
        .load_i  (cnt_load),
        .inc_i   (cnt_inc),
        .count_o (row_cnt),
        .last_o  (row_last)
    );

    // Frame FSM with registered outputs; ready drops through the pre-strobe
    // and strobe cycles so a following header lands once the strobe is done.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            s_ready_q    <= 1'b0;
            frame_data_q <= '0;
            row_sel_q    <= '0;
            frame_addr_q <= '0;
            strobe_q     <= 1'b0;
            err_q        <= 1'b0;
`ifdef FRAME_DATA_WRITER_CHECK_EN
            xor_q        <= '0;
`endif
        end else begin
            // NOTE: pulse outputs default low each cycle; only an accepted word or the strobe state raises them.
            row_sel_q <= '0;
            strobe_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    s_ready_q <= 1'b1;
                    if (fire) begin
                        if (hdr_ok) begin
                            frame_addr_q <= s_if.s_data[FrameAddrWidth-1:0];
                            state_q      <= ST_DATA;
`ifdef FRAME_DATA_WRITER_CHECK_EN
                            xor_q        <= '0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    s_ready_q <= 1'b1;
                    if (fire) begin
                        frame_data_q <= s_if.s_data;
                        row_sel_q    <= row_cnt;
`ifdef FRAME_DATA_WRITER_CHECK_EN
                        xor_q        <= xor_q ^ s_if.s_data;
                        if (row_last) begin
                            state_q <= ST_CHECK;
                        end
`else
                        if (row_last) begin
                            state_q   <= ST_STROBE;
                            s_ready_q <= 1'b0;
                        end
`endif
                    end
                end
`ifdef FRAME_DATA_WRITER_CHECK_EN
                ST_CHECK: begin
                    s_ready_q <= 1'b1;
                    if (fire) begin
                        if (s_if.s_data == xor_q) begin
                            state_q   <= ST_STROBE;
                            s_ready_q <= 1'b0;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
`endif
                ST_STROBE: begin
                    strobe_q  <= 1'b1;
                    s_ready_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_if.s_ready = s_ready_q;
    assign FrameData    = frame_data_q;
    assign RowSelect    = row_sel_q;
    assign FrameAddr    = frame_addr_q;
    assign FrameStrobe  = strobe_q;
    assign err          = err_q;

endmodule

// File: tb/tb_frame_data_writer.sv
// Self-checking bench for frame_data_writer: directed frames plus randomized
// data, addresses and stream gaps, compared against a frame-level model.
module tb_frame_data_writer;

    logic        clk;
    logic        resetn;
    logic [31:0] FrameData;
    logic [4:0]  RowSelect;
    logic [4:0]  FrameAddr;
    logic        FrameStrobe;
    logic        err;

    frame_data_writer_if #(.Width(32)) s_if ();

    frame_data_writer dut (
        .CLK         (clk),
        .resetn      (resetn),
        .s_if        (s_if),
        .FrameData   (FrameData),
        .RowSelect   (RowSelect),
        .FrameAddr   (FrameAddr),
        .FrameStrobe (FrameStrobe),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation logs, filled at each falling edge.
    int          cyc = 0;
    int          rs_q[$];
    logic [31:0] fd_q[$];
    logic [4:0]  fa_q[$];
    int          rs_cyc_q[$];
    int          strobe_cyc_q[$];
    logic        strobe_rdy_q[$];
    int          fire_cyc_q[$];

    // Model state.
    logic [31:0] rows_exp[12];
    logic        err_exp = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (RowSelect != 5'd0) begin
            rs_q.push_back(int'(RowSelect));
            fd_q.push_back(FrameData);
            fa_q.push_back(FrameAddr);
            rs_cyc_q.push_back(cyc);
        end
        if (FrameStrobe) begin
            strobe_cyc_q.push_back(cyc);
            strobe_rdy_q.push_back(s_if.s_ready);
        end
        if (s_if.s_valid && s_if.s_ready) begin
            fire_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rs_q.delete();
        fd_q.delete();
        fa_q.delete();
        rs_cyc_q.delete();
        strobe_cyc_q.delete();
        strobe_rdy_q.delete();
        fire_cyc_q.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the word transferred.
    task automatic send(input logic [31:0] w);
        int n = 0;
        s_if.s_valid = 1'b1;
        s_if.s_data  = w;
        @(negedge clk);
        while (!s_if.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("handshake_ready", s_if.s_ready, 1'b1);
        @(posedge clk);
        #1;
        s_if.s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] frame_xor();
        logic [31:0] x = '0;
        for (int i = 0; i < 12; i++) x ^= rows_exp[i];
        return x;
    endfunction

    function automatic logic [31:0] header(input logic [4:0] addr);
        return {16'hFAB0, 11'd0, addr};
    endfunction

    // Rows with a random gap in [gmin,gmax] after each; check word when built in.
    task automatic send_body(input int gmin, input int gmax);
        for (int i = 0; i < 12; i++) begin
            send(rows_exp[i]);
            idle(int'($urandom_range(gmax, gmin)));
        end
`ifdef FRAME_DATA_WRITER_CHECK_EN
        send(frame_xor());
`endif
    endtask

    task automatic randomize_rows();
        for (int i = 0; i < 12; i++) rows_exp[i] = $urandom;
    endtask

    // Frame-level model: each row written once, in order, with its data and
    // the header's frame index; strobe count and sticky error as expected.
    task automatic verify_frame(input string tag, input logic [4:0] addr, input int exp_strobes);
        check({tag, "_row_count"}, rs_q.size(), 12);
        for (int i = 0; i < rs_q.size() && i < 12; i++) begin
            check({tag, "_rowsel"}, rs_q[i], i + 1);
            check({tag, "_framedata"}, fd_q[i], rows_exp[i]);
            check({tag, "_frameaddr"}, fa_q[i], addr);
        end
        check({tag, "_strobe_count"}, strobe_cyc_q.size(), exp_strobes);
        check({tag, "_err"}, err, err_exp);
    endtask

    initial begin
        logic [4:0] addr;
        resetn      = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;

        // Reset state.
        idle(2);
        check("rst_framedata", FrameData, 32'd0);
        check("rst_rowselect", RowSelect, 5'd0);
        check("rst_frameaddr", FrameAddr, 5'd0);
        check("rst_strobe", FrameStrobe, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ready", s_if.s_ready, 1'b0);
        resetn = 1'b1;
        idle(1);

        // Back-to-back frame 1..12 at index 3, next header straight after.
        clear_logs();
        for (int i = 0; i < 12; i++) rows_exp[i] = 32'(i + 1);
        send(32'hFAB0_0003);
        send_body(0, 0);
        addr = 5'($urandom_range(31, 0));
        send(header(addr));
        verify_frame("b2b", 5'd3, 1);
        if (rs_cyc_q.size() == 12) begin
            for (int i = 1; i < 12; i++) check("b2b_consecutive", rs_cyc_q[i] - rs_cyc_q[0], i);
`ifndef FRAME_DATA_WRITER_CHECK_EN
            if (strobe_cyc_q.size() > 0) check("b2b_strobe_after_last_row", strobe_cyc_q[0], rs_cyc_q[11] + 1);
`endif
        end
        if (strobe_cyc_q.size() > 0 && fire_cyc_q.size() > 0) begin
            check("strobe_ready_low", strobe_rdy_q[0], 1'b0);
            check("header_after_strobe", fire_cyc_q[fire_cyc_q.size() - 1], strobe_cyc_q[0] + 1);
        end

        // Random frame under the header already accepted.
        clear_logs();
        randomize_rows();
        send_body(0, 2);
        idle(4);
        verify_frame("rand_after_strobe", addr, 1);

        // Valid toggled every other cycle: RowSelect pulses separated by one 0.
        clear_logs();
        for (int i = 0; i < 12; i++) rows_exp[i] = 32'(i + 1);
        send(32'hFAB0_0003);
        idle(1);
        send_body(1, 1);
        idle(4);
        verify_frame("toggle", 5'd3, 1);
        if (rs_cyc_q.size() == 12) begin
            for (int i = 1; i < 12; i++) check("toggle_gap", rs_cyc_q[i] - rs_cyc_q[i-1], 2);
        end

        // Bad magic in IDLE: sticky error, no row or strobe.
        clear_logs();
        send(32'h1234_0000);
        idle(3);
        err_exp = 1'b1;
        check("badmagic_err", err, 1'b1);
        check("badmagic_rows", rs_q.size(), 0);
        check("badmagic_strobe", strobe_cyc_q.size(), 0);
        clear_logs();
        randomize_rows();
        addr = 5'($urandom_range(31, 0));
        send(header(addr));
        send_body(0, 1);
        idle(4);
        verify_frame("after_badmagic", addr, 1);

        // Reset after row 5: outputs clear asynchronously, no strobe.
        clear_logs();
        randomize_rows();
        send(32'hFAB0_0007);
        for (int i = 0; i < 5; i++) send(rows_exp[i]);
        idle(1);
        #2;
        resetn = 1'b0;
        #1;
        err_exp = 1'b0;
        check("midrst_framedata", FrameData, 32'd0);
        check("midrst_rowselect", RowSelect, 5'd0);
        check("midrst_frameaddr", FrameAddr, 5'd0);
        check("midrst_strobe", FrameStrobe, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_ready", s_if.s_ready, 1'b0);
        idle(2);
        resetn = 1'b1;
        idle(3);
        check("midrst_rows_seen", rs_q.size(), 5);
        check("midrst_no_strobe", strobe_cyc_q.size(), 0);
        clear_logs();
        randomize_rows();
        addr = 5'($urandom_range(31, 0));
        send(header(addr));
        send_body(0, 2);
        idle(4);
        verify_frame("after_reset", addr, 1);

        // Randomized frames.
        for (int f = 0; f < 4; f++) begin
            clear_logs();
            randomize_rows();
            addr = 5'($urandom_range(31, 0));
            send(header(addr));
            idle(int'($urandom_range(2, 0)));
            send_body(0, 3);
            idle(4);
            verify_frame("rand", addr, 1);
        end

`ifdef FRAME_DATA_WRITER_CHECK_EN
        // Check word equal to XOR of 1..12 (12) passes.
        clear_logs();
        for (int i = 0; i < 12; i++) rows_exp[i] = 32'(i + 1);
        send(32'hFAB0_0001);
        for (int i = 0; i < 12; i++) send(rows_exp[i]);
        send(32'h0000_000C);
        idle(4);
        verify_frame("check_ok", 5'd1, 1);
        // Check word 0 fails: error, no strobe.
        clear_logs();
        send(32'hFAB0_0002);
        for (int i = 0; i < 12; i++) send(rows_exp[i]);
        send(32'h0000_0000);
        idle(4);
        err_exp = 1'b1;
        verify_frame("check_bad", 5'd2, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
